arc4_encrypt: RTL

//  ARC4 encryptor; the writer counterpart of the crack/arc4 decrypt path.

---
 rtl/arc4_pkg.sv | 36 +++
 rtl/arc4_encrypt_s_mem.sv | 24 ++
 rtl/arc4_encrypt.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/arc4_pkg.sv
// Shared states, constants and helpers for the ARC4 encryptor.
// The optional plaintext printable-range check is enabled with ARC4_PT_CHECK_EN.
package arc4_pkg;

    localparam int         ARC4_N   = 256;
    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    // Top-level phases, each split into the sub-steps that hide the S RAM read latency
    typedef enum logic [4:0] {
        IDLE,
        INIT,
        KSA_RD_I,
        KSA_WAIT_I,
        KSA_RD_J,
        KSA_WR_J,
        KSA_WR_I,
        LEN_RD,
        LEN_WAIT,
        LEN_WR,
        PRGA_RD_I,
        PRGA_WAIT_I,
        PRGA_RD_J,
        PRGA_WR_J,
        PRGA_WR_I,
        PRGA_RD_PAD,
        PRGA_WAIT_PAD,
        PRGA_OUT,
        DONE
    } arc4_state_t;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= PRINT_LO) && (b <= PRINT_HI);
    endfunction

endpackage

// File: rtl/arc4_encrypt_s_mem.sv
// 256x8 single-port synchronous RAM holding the ARC4 state array S.
// Registered read with one cycle of latency; stands in for an altsyncram instance.
module s_mem (
    input  logic       i_clk,
    input  logic [7:0] i_addr,
    input  logic [7:0] i_wrdata,
    input  logic       i_wren,
    output logic [7:0] o_rddata
);

    logic [7:0] r_mem [0:255];
    logic [7:0] r_rddata;

    // Read returns the pre-write contents when a write hits the same address
    always_ff @(posedge i_clk) begin
        if (i_wren) begin
            r_mem[i_addr] <= i_wrdata;
        end
        r_rddata <= r_mem[i_addr];
    end

    assign o_rddata = r_rddata;

endmodule

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: reads a length-prefixed plaintext RAM and writes the ciphertext image.
// Define ARC4_PT_CHECK_EN to add o_pt_ok, a printable-ASCII check over the message bytes.
module arc4_encrypt
    import arc4_pkg::*;
#(
    parameter int KEY_BYTES = 3
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_en,
    output logic                   o_rdy,
    input  logic [8*KEY_BYTES-1:0] i_key,
    output logic [7:0]             o_pt_addr,
    input  logic [7:0]             i_pt_rddata,
    output logic [7:0]             o_ct_addr,
    output logic [7:0]             o_ct_wrdata,
`ifdef ARC4_PT_CHECK_EN
    output logic                   o_ct_wren,
    output logic                   o_pt_ok
`else
    output logic                   o_ct_wren
`endif
);

    localparam logic [7:0] KIDX_LAST = 8'(KEY_BYTES - 1);
    localparam logic [7:0] S_LAST    = 8'(ARC4_N - 1);

    arc4_state_t            r_state;
    logic [8*KEY_BYTES-1:0] r_key;
    logic [7:0]             r_kidx;
    logic [7:0]             r_i;
    logic [7:0]             r_j;
    logic [7:0]             r_k;
    logic [7:0]             r_len;
    logic [7:0]             r_si;
    logic [7:0]             r_sj;
    logic [7:0]             r_pt_byte;
    logic                   r_rdy;
    logic [7:0]             r_pt_addr;
    logic [7:0]             r_ct_addr;
    logic [7:0]             r_ct_wrdata;
    logic                   r_ct_wren;
    logic [7:0]             r_s_addr;
    logic [7:0]             r_s_wrdata;
    logic                   r_s_wren;
    logic [7:0]             w_s_rddata;
    logic [7:0]             w_keybyte;
`ifdef ARC4_PT_CHECK_EN
    logic                   r_pt_ok;
`endif

    s_mem u_s_mem (
        .i_clk    (i_clk),
        .i_addr   (r_s_addr),
        .i_wrdata (r_s_wrdata),
        .i_wren   (r_s_wren),
        .o_rddata (w_s_rddata)
    );

    // Key byte 0 is the most significant byte of the key word
    always_comb begin
        w_keybyte = '0;
        for (int n = 0; n < KEY_BYTES; n++) begin
            if (r_kidx == 8'(n)) begin
                w_keybyte = r_key[8*(KEY_BYTES-n)-1 -: 8];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_key       <= '0;
            r_kidx      <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_k         <= '0;
            r_len       <= '0;
            r_si        <= '0;
            r_sj        <= '0;
            r_pt_byte   <= '0;
            r_rdy       <= 1'b1;
            r_pt_addr   <= '0;
            r_ct_addr   <= '0;
            r_ct_wrdata <= '0;
            r_ct_wren   <= 1'b0;
            r_s_addr    <= '0;
            r_s_wrdata  <= '0;
            r_s_wren    <= 1'b0;
`ifdef ARC4_PT_CHECK_EN
            r_pt_ok     <= 1'b1;
`endif
        end else begin
            r_ct_wren <= 1'b0;
            r_s_wren  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_en && r_rdy) begin
                        r_key   <= i_key;
                        r_rdy   <= 1'b0;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_kidx  <= '0;
                        r_state <= INIT;
`ifdef ARC4_PT_CHECK_EN
                        r_pt_ok <= 1'b1;
`endif
                    end
                end
                INIT: begin
                    r_s_addr   <= r_i;
                    r_s_wrdata <= r_i;
                    r_s_wren   <= 1'b1;
                    r_i        <= r_i + 8'd1;
                    if (r_i == S_LAST) begin
                        r_state <= KSA_RD_I;
                    end
                end
                KSA_RD_I: begin
                    r_s_addr <= r_i;
                    r_state  <= KSA_WAIT_I;
                end
                KSA_WAIT_I: begin
                    r_state <= KSA_RD_J;
                end
                KSA_RD_J: begin
                    r_si     <= w_s_rddata;
                    r_j      <= r_j + w_s_rddata + w_keybyte;
                    r_s_addr <= r_j + w_s_rddata + w_keybyte;
                    r_kidx   <= (r_kidx == KIDX_LAST) ? 8'd0 : r_kidx + 8'd1;
                    r_state  <= KSA_WR_J;
                end
                // S[j] was sampled last edge, so it can be overwritten before its value is consumed
                KSA_WR_J: begin
                    r_s_addr   <= r_j;
                    r_s_wrdata <= r_si;
                    r_s_wren   <= 1'b1;
                    r_state    <= KSA_WR_I;
                end
                KSA_WR_I: begin
                    r_s_addr   <= r_i;
                    r_s_wrdata <= w_s_rddata;
                    r_s_wren   <= 1'b1;
                    if (r_i == S_LAST) begin
                        r_state <= LEN_RD;
                    end else begin
                        r_i     <= r_i + 8'd1;
                        r_state <= KSA_RD_I;
                    end
                end
                LEN_RD: begin
                    r_pt_addr <= 8'd0;
                    r_state   <= LEN_WAIT;
                end
                LEN_WAIT: begin
                    r_state <= LEN_WR;
                end
                LEN_WR: begin
                    r_len       <= i_pt_rddata;
                    r_ct_addr   <= 8'd0;
                    r_ct_wrdata <= i_pt_rddata;
                    r_ct_wren   <= 1'b1;
                    r_i         <= '0;
                    r_j         <= '0;
                    r_k         <= 8'd1;
                    r_state     <= (i_pt_rddata <= 8'd1) ? DONE : PRGA_RD_I;
                end
                PRGA_RD_I: begin
                    r_i       <= r_i + 8'd1;
                    r_s_addr  <= r_i + 8'd1;
                    r_pt_addr <= r_k;
                    r_state   <= PRGA_WAIT_I;
                end
                PRGA_WAIT_I: begin
                    r_state <= PRGA_RD_J;
                end
                PRGA_RD_J: begin
                    r_si      <= w_s_rddata;
                    r_j       <= r_j + w_s_rddata;
                    r_s_addr  <= r_j + w_s_rddata;
                    r_pt_byte <= i_pt_rddata;
`ifdef ARC4_PT_CHECK_EN
                    r_pt_ok   <= r_pt_ok & is_printable(i_pt_rddata);
`endif
                    r_state   <= PRGA_WR_J;
                end
                PRGA_WR_J: begin
                    r_s_addr   <= r_j;
                    r_s_wrdata <= r_si;
                    r_s_wren   <= 1'b1;
                    r_state    <= PRGA_WR_I;
                end
                PRGA_WR_I: begin
                    r_sj       <= w_s_rddata;
                    r_s_addr   <= r_i;
                    r_s_wrdata <= w_s_rddata;
                    r_s_wren   <= 1'b1;
                    r_state    <= PRGA_RD_PAD;
                end
                PRGA_RD_PAD: begin
                    r_s_addr <= r_si + r_sj;
                    r_state  <= PRGA_WAIT_PAD;
                end
                PRGA_WAIT_PAD: begin
                    r_state <= PRGA_OUT;
                end
                PRGA_OUT: begin
                    r_ct_addr   <= r_k;
                    r_ct_wrdata <= r_pt_byte ^ w_s_rddata;
                    r_ct_wren   <= 1'b1;
                    if (r_k == r_len - 8'd1) begin
                        r_state <= DONE;
                    end else begin
                        r_k     <= r_k + 8'd1;
                        r_state <= PRGA_RD_I;
                    end
                end
                DONE: begin
                    r_rdy   <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_rdy       = r_rdy;
    assign o_pt_addr   = r_pt_addr;
    assign o_ct_addr   = r_ct_addr;
    assign o_ct_wrdata = r_ct_wrdata;
    assign o_ct_wren   = r_ct_wren;
`ifdef ARC4_PT_CHECK_EN
    assign o_pt_ok     = r_pt_ok;
`endif

endmodule
